// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port single-cycle memory arbiter with fixed-latency responses
// Define MEM_ARBITER_RR_EN for round-robin contention; default is fixed priority to port 0.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  logic gnt0, gnt1, any_gnt;
  logic last_grant, last_grant_d;
  logic pend_valid, pend_owner, pend_read;

  // Grants are suppressed while in reset so nothing can be accepted in that cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
`ifdef MEM_ARBITER_RR_EN
        gnt0 = last_grant;
        gnt1 = ~last_grant;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign any_gnt    = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    last_grant_d = last_grant;
    if (any_gnt) last_grant_d = gnt1;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (gnt1) begin
      mem_we   = req1_we;
      mem_re   = ~req1_we;
      mem_addr = req1_addr;
      mem_wd   = req1_wdata;
    end else if (gnt0) begin
      mem_we   = req0_we;
      mem_re   = ~req0_we;
      mem_addr = req0_addr;
      mem_wd   = req0_wdata;
    end
  end

  // last_grant resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_owner <= 1'b0;
      pend_read  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      pend_valid <= any_gnt;
      pend_owner <= gnt1;
      pend_read  <= mem_re;
      last_grant <= last_grant_d;
    end
  end

  assign rsp0_valid = pend_valid & ~pend_owner & ~rst;
  assign rsp1_valid = pend_valid &  pend_owner & ~rst;
  assign rsp0_rdata = (rsp0_valid && pend_read) ? mem_rd : '0;
  assign rsp1_rdata = (rsp1_valid && pend_read) ? mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Honours MEM_ARBITER_RR_EN to select the expected contention policy.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 11;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_we, req0_ready, req1_valid, req1_we, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, mem_addr;
  logic [DW-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, mem_wd, mem_rd;
  logic rsp0_valid, rsp1_valid, mem_we, mem_re;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Attached memory: 16 words, read data one cycle after mem_re.
  logic [DW-1:0] mem [0:15];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[3:0]] <= mem_wd;
    end
    if (mem_re) mem_rd <= mem[mem_addr[3:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic we1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic v0, we0, v1, we1;
    logic [AW-1:0] a0, a1;
    logic e_r0, e_r1, e_we, e_re, e_rsp0, e_rsp1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
  } vec_t;
  vec_t tbl [6];

  logic [DW-1:0] refmem [0:15];
  logic hold [2], acc [2], rq_we [2];
  logic [AW-1:0] rq_addr [2];
  logic [DW-1:0] rq_wd [2];
  logic exp_pend, exp_own, last_m;
  logic [DW-1:0] exp_data;
  int win;

  initial begin
    // v0 we0 v1 we1 a0 a1 | r0 r1 we re rsp0 rsp1 addr wd
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0};
    tbl[1] = '{1, 1, 0, 0, 7, 0, 1, 0, 1, 0, 0, 0, 7, 32'h1007};
    tbl[2] = '{0, 0, 1, 0, 0, 9, 0, 1, 0, 1, 1, 0, 9, 32'h2009};
    tbl[3] = '{1, 0, 1, 1, 2, 3, 1, 0, 0, 1, 0, 1, 2, 32'h1002};
    tbl[4] = '{0, 0, 1, 1, 0, 4, 0, 1, 1, 0, 1, 0, 4, 32'h2004};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0};

    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk);
    check("rst_ready0", req0_ready, 0);
    check("rst_rsp0", rsp0_valid, 0);
    check("rst_mem_re", mem_re, 0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, 32'h1000 + 32'(tbl[i].a0),
            tbl[i].v1, tbl[i].we1, tbl[i].a1, 32'h2000 + 32'(tbl[i].a1));
      @(negedge clk);
      check($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].e_r0);
      check($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].e_r1);
      check($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
      check($sformatf("tbl%0d_mem_re", i), mem_re, tbl[i].e_re);
      check($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_mem_wd", i), mem_wd, tbl[i].e_wd);
      check($sformatf("tbl%0d_rsp0", i), rsp0_valid, tbl[i].e_rsp0);
      check($sformatf("tbl%0d_rsp1", i), rsp1_valid, tbl[i].e_rsp1);
      next_cycle();
    end

    // Write then read back through the other port.
    do_reset();
    drive(1, 1, 5, 32'hDEADBEEF, 0, 0, '0, '0);
    @(negedge clk); check("wr_ready0", req0_ready, 1);
    next_cycle(); drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk); check("wr_rsp0", rsp0_valid, 1); check("wr_rdata0", rsp0_rdata, 0);
    next_cycle(); drive(0, 0, '0, '0, 1, 0, 5, '0);
    @(negedge clk); check("rd_ready1", req1_ready, 1); check("rd_rsp1_early", rsp1_valid, 0);
    next_cycle(); drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk); check("rd_rsp1", rsp1_valid, 1); check("rd_rdata1", rsp1_rdata, 32'hDEADBEEF);
    next_cycle();

    // Sustained contention.
    do_reset();
    drive(1, 0, 1, '0, 1, 0, 2, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("cont%0d_ready0", i), req0_ready, RR ? ((i % 2) == 0) : 1'b1);
      check($sformatf("cont%0d_ready1", i), req1_ready, RR ? ((i % 2) == 1) : 1'b0);
      next_cycle();
    end

    // Back-to-back reads from one port.
    do_reset();
    drive(1, 1, 3, 32'hA3, 0, 0, '0, '0); next_cycle();
    drive(1, 1, 4, 32'hB4, 0, 0, '0, '0); next_cycle();
    drive(1, 0, 3, '0, 0, 0, '0, '0);
    @(negedge clk); check("b2b_re0", mem_re, 1); check("b2b_ready0", req0_ready, 1);
    next_cycle(); drive(1, 0, 4, '0, 0, 0, '0, '0);
    @(negedge clk); check("b2b_re1", mem_re, 1); check("b2b_rsp_a", rsp0_valid, 1);
    check("b2b_rdata_a", rsp0_rdata, 32'hA3);
    next_cycle(); drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk); check("b2b_re_off", mem_re, 0); check("b2b_rsp_b", rsp0_valid, 1);
    check("b2b_rdata_b", rsp0_rdata, 32'hB4);
    next_cycle();
    @(negedge clk); check("b2b_rsp_end", rsp0_valid, 0);
    next_cycle();

    // Reset lands on an accepted read and a response cycle.
    do_reset();
    drive(1, 0, 5, '0, 0, 0, '0, '0);
    @(negedge clk); check("rr_ready0", req0_ready, 1);
    next_cycle(); rst = 1'b1; drive(1, 0, 6, '0, 0, 0, '0, '0);
    @(negedge clk); check("rr_rst_ready0", req0_ready, 0); check("rr_rst_rsp0", rsp0_valid, 0);
    check("rr_rst_addr", mem_addr, 0); check("rr_rst_rdata0", rsp0_rdata, 0);
    next_cycle(); rst = 1'b0; drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk); check("rr_post_rsp0", rsp0_valid, 0); check("rr_post_rsp1", rsp1_valid, 0);
    next_cycle(); drive(1, 0, 1, '0, 1, 0, 2, '0);
    @(negedge clk); check("rr_first_ready0", req0_ready, 1); check("rr_first_ready1", req1_ready, 0);
    next_cycle();

    // Random two-port traffic against a reference memory and response queue.
    do_reset();
    for (int i = 0; i < 16; i++) refmem[i] = '0;
    for (int p = 0; p < 2; p++) begin hold[p] = 0; acc[p] = 0; end
    exp_pend = 0; exp_own = 0; exp_data = '0; last_m = 1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) hold[p] = 0;
        acc[p] = 0;
        if (!hold[p] && $urandom_range(0, 3) != 0) begin
          hold[p] = 1;
          rq_we[p] = 1'($urandom_range(0, 1));
          rq_addr[p] = AW'($urandom_range(0, 15));
          rq_wd[p] = $urandom;
        end
      end
      drive(hold[0], rq_we[0], rq_addr[0], rq_wd[0], hold[1], rq_we[1], rq_addr[1], rq_wd[1]);
      @(negedge clk);
      if (hold[0] && hold[1]) win = RR ? (last_m ? 0 : 1) : 0;
      else if (hold[0]) win = 0;
      else if (hold[1]) win = 1;
      else win = -1;
      check("rnd_ready0", req0_ready, win == 0);
      check("rnd_ready1", req1_ready, win == 1);
      check("rnd_rsp0", rsp0_valid, exp_pend && !exp_own);
      check("rnd_rsp1", rsp1_valid, exp_pend && exp_own);
      check("rnd_rdata0", rsp0_rdata, (exp_pend && !exp_own) ? exp_data : '0);
      check("rnd_rdata1", rsp1_rdata, (exp_pend && exp_own) ? exp_data : '0);
      check("rnd_rsp_overlap", rsp0_valid & rsp1_valid, 0);
      if (win >= 0) begin
        exp_pend = 1;
        exp_own = (win == 1);
        if (rq_we[win]) begin
          exp_data = '0;
          refmem[rq_addr[win][3:0]] = rq_wd[win];
        end else begin
          exp_data = refmem[rq_addr[win][3:0]];
        end
        acc[win] = 1;
        last_m = (win == 1);
      end else begin
        exp_pend = 0;
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of data buses.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, giving the width of word-address buses.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester N presents an access.
REQ-006 SHALL have ports req0_we / req1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports req0_addr / req1_addr, input, ADDR_WIDTH each: word address.
REQ-008 SHALL have ports req0_wdata / req1_wdata, input, DATA_WIDTH each: write data.
REQ-009 SHALL have ports req0_ready / req1_ready, output, 1 bit each: request accepted this cycle.
REQ-010 SHALL have ports rsp0_valid / rsp1_valid, output, 1 bit each: response for requester N.
REQ-011 SHALL have ports rsp0_rdata / rsp1_rdata, output, DATA_WIDTH each: read data.
REQ-012 SHALL have ports mem_we / mem_re, output, 1 bit each: memory write and read strobes.
REQ-013 SHALL have port mem_addr, output, ADDR_WIDTH: memory address.
REQ-014 SHALL have port mem_wd, output, DATA_WIDTH: memory write data.
REQ-015 SHALL have port mem_rd, input, DATA_WIDTH: memory read data, valid one cycle after mem_re.

Function
REQ-016 SHALL accept at most one request per cycle; reqN_ready SHALL be high only for the granted port, in the same cycle as its valid (combinational grant).
REQ-017 SHALL drive mem_we/mem_re/mem_addr/mem_wd combinationally from the granted request; with no grant, mem_we=0, mem_re=0, mem_addr=0, mem_wd=0.
REQ-018 SHALL, with a single valid requester, grant it unconditionally.
REQ-019 SHALL, with both requesters valid, grant per the arbitration policy (REQ-030/031); the loser's ready SHALL be 0.
REQ-020 SHALL register owner and type of each accepted access and assert rspN_valid for exactly one cycle, one cycle after acceptance (fixed latency 1).
REQ-021 SHALL, for reads, drive rspN_rdata = mem_rd in the response cycle; for writes, rspN_rdata = 0.
REQ-022 SHALL hold rspN_rdata = 0 whenever rspN_valid = 0.
REQ-023 SHALL sustain back-to-back acceptance every cycle, including alternating ports, with no bubble.
REQ-024 SHALL never assert rsp0_valid and rsp1_valid in the same cycle.
REQ-025 SHALL require a requester to hold valid, we, addr and wdata stable until ready; a valid dropped before ready SHALL leave no side effect.
REQ-026 SHALL keep last_grant (1 bit) updated to the granted port on every grant and unchanged in cycles without a grant.

Reset
REQ-027 SHALL, while rst=1, drive all ready, rsp_valid, mem_we, mem_re to 0 and mem_addr, mem_wd, rspN_rdata to 0.
REQ-028 SHALL, on reset, clear the pending-response register and set last_grant=1, so that port 0 wins the first contention.
REQ-029 SHALL discard an access accepted in the cycle reset is asserted; no rsp_valid SHALL appear in the cycle after reset.

Configuration
REQ-030 SHALL, with macro MEM_ARBITER_RR_EN defined, resolve contention round-robin: the winner is the port not equal to last_grant.
REQ-031 SHALL, without MEM_ARBITER_RR_EN, resolve contention by fixed priority: port 0 always wins, and last_grant SHALL still be tracked.

Verification
REQ-032 SHALL pass: req0 write addr 5 data 0xDEADBEEF, then req1 read addr 5 -> req0_ready in cycle 0, rsp0_valid in cycle 1 with rdata 0; rsp1_valid in cycle 3 with rdata 0xDEADBEEF.
REQ-033 SHALL pass: both ports hold reads for 4 cycles with RR_EN -> grants 0,1,0,1; without RR_EN -> grants 0,0,0,0 and req1_ready is never asserted.
REQ-034 SHALL pass: req0 reads addr 3 and addr 4 in consecutive cycles -> mem_re is high for 2 cycles, and rsp0_valid is high for 2 cycles with in-order data.
REQ-035 SHALL pass: reset asserted in the cycle a read is accepted -> no rsp_valid afterwards, and the first contention after reset is granted to port 0.
REQ-036 SHALL pass: a random 1000-cycle two-port traffic run against a reference memory model -> every read returns the last written value, exactly one response per acceptance, and no simultaneous rsp_valid.
